// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter slice.
//   DATA_WD / DATA_BYTE_WD : default stream data and keep widths
//   state_t                : arbiter FSM state encoding (IDLE, XFER)
//   slice_lo()             : low bit of slice idx in a flattened bus
package axis_pkg;

  localparam int DATA_WD      = 32;
  localparam int DATA_BYTE_WD = DATA_WD / 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic int slice_lo(input int idx, input int wd);
    return idx * wd;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, bit i = requester i
//   last_grant : index granted most recently
//   winner     : first requester found scanning upward from last_grant+1 with wrap
//   any_req    : at least one request bit is set
module rr_pick #(
  parameter int NUM_SRC = 2,
  parameter int SRC_WD  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_WD-1:0]  last_grant,
  output logic [SRC_WD-1:0]  winner,
  output logic               any_req
);

  logic found;

  // Two passes: first the indices above last_grant, then the wrapped-around
  // ones up to and including last_grant. First hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && req[j] && (j > int'(last_grant))) begin
        winner = SRC_WD'(j);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && req[j] && (j <= int'(last_grant))) begin
        winner = SRC_WD'(j);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI-Stream sources share one
// AXI-Stream output. A grant is held from the first beat until the last-beat
// handshake, so packets never interleave.
//   clk, rst           : clock, synchronous active-high reset
//   valid_s/data_s/keep_s/last_s/ready_s : flattened source streams
//   valid_m/data_m/keep_m/last_m/ready_m : output stream
//   grant_idx          : source owning the output
//   busy               : a grant is held (FSM in XFER)
//   err_oversize       : sticky, a packet exceeded MAX_BEATS handshakes
//
// Handshake: a beat moves when valid and ready are both high on a rising
// edge; valid never waits on ready, and ready_s is only ever raised towards
// the granted source, mirroring ready_m combinationally.
module axis_pkt_arbiter #(
  parameter int DATA_WD      = axis_pkg::DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 2,
  parameter int SRC_WD       = $clog2(NUM_SRC),
  parameter int MAX_BEATS    = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              valid_s,
  input  logic [NUM_SRC*DATA_WD-1:0]      data_s,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] keep_s,
  input  logic [NUM_SRC-1:0]              last_s,
  output logic [NUM_SRC-1:0]              ready_s,
  output logic                            valid_m,
  output logic [DATA_WD-1:0]              data_m,
  output logic [DATA_BYTE_WD-1:0]         keep_m,
  output logic                            last_m,
  input  logic                            ready_m,
  output logic [SRC_WD-1:0]               grant_idx,
  output logic                            busy,
  output logic                            err_oversize
);

  import axis_pkg::*;

  // Counter must hold MAX_BEATS+1 (saturation value).
  localparam int CNT_WD = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_WD-1:0] CNT_SAT = CNT_WD'(MAX_BEATS + 1);
  localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(MAX_BEATS);

  state_t              state, state_d;
  logic [SRC_WD-1:0]   grant_q, grant_d;
  logic [SRC_WD-1:0]   last_grant_q, last_grant_d;
  logic [SRC_WD-1:0]   pick_idx;
  logic                any_req;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                hs;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_WD  (SRC_WD)
  ) u_rr_pick (
    .req        (valid_s),
    .last_grant (last_grant_q),
    .winner     (pick_idx),
    .any_req    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_WD'(NUM_SRC - 1);
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Output mux: straight combinational path from the granted source.
  always_comb begin
    valid_m = 1'b0;
    data_m  = '0;
    keep_m  = '0;
    last_m  = 1'b0;
    ready_s = '0;
    if (state == XFER) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == SRC_WD'(i)) begin
          valid_m    = valid_s[i];
          data_m     = data_s[slice_lo(i, DATA_WD) +: DATA_WD];
          keep_m     = keep_s[slice_lo(i, DATA_BYTE_WD) +: DATA_BYTE_WD];
          last_m     = last_s[i];
          ready_s[i] = ready_m;
        end
      end
    end
  end

  assign hs = valid_m & ready_m;

  always_comb begin
    state_d      = state;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_d = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        if (hs) begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_WD'(1);
          // cnt_q counts completed beats; this handshake is beat cnt_q+1.
          if (cnt_q >= CNT_MAX) err_d = 1'b1;
          if (last_m) begin
            last_grant_d = grant_q;
            cnt_d        = '0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_idx    = grant_q;
  assign busy         = (state == XFER);
  assign err_oversize = err_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter (3 sources, MAX_BEATS=4).
module tb_axis_pkt_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int BW = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      valid_s;
  logic [N*DW-1:0]   data_s;
  logic [N*BW-1:0]   keep_s;
  logic [N-1:0]      last_s;
  logic [N-1:0]      ready_s;
  logic              valid_m;
  logic [DW-1:0]     data_m;
  logic [BW-1:0]     keep_m;
  logic              last_m;
  logic              ready_m;
  logic [1:0]        grant_idx;
  logic              busy;
  logic              err_oversize;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  axis_pkt_arbiter #(
    .DATA_WD      (DW),
    .DATA_BYTE_WD (BW),
    .NUM_SRC      (N),
    .SRC_WD       (2),
    .MAX_BEATS    (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .valid_s      (valid_s),
    .data_s       (data_s),
    .keep_s       (keep_s),
    .last_s       (last_s),
    .ready_s      (ready_s),
    .valid_m      (valid_m),
    .data_m       (data_m),
    .keep_m       (keep_m),
    .last_m       (last_m),
    .ready_m      (ready_m),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .err_oversize (err_oversize)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_src(input int i, input logic v, input logic [31:0] d,
                         input logic [3:0] k, input logic l);
    valid_s[i]          = v;
    data_s[i*DW +: DW]  = d;
    keep_s[i*BW +: BW]  = k;
    last_s[i]           = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_s = '0;
    data_s  = '0;
    keep_s  = '0;
    last_s  = '0;
    ready_m = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // ---------------- reset state
    settle();
    chk("rst_valid_m", 32'(valid_m), 32'd0);
    chk("rst_ready_s", 32'(ready_s), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_grant",   32'(grant_idx), 32'd0);
    chk("rst_err",     32'(err_oversize), 32'd0);
    chk("rst_last_m",  32'(last_m), 32'd0);

    // ---------------- single requester, 3 beats
    cyc();
    ready_m = 1'b1;
    set_src(0, 1'b1, 32'h11, 4'hF, 1'b0);
    settle();
    chk("t1_idle_valid", 32'(valid_m), 32'd0);
    cyc();
    settle();
    chk("t1_b1_valid", 32'(valid_m), 32'd1);
    chk("t1_b1_data",  data_m, 32'h11);
    chk("t1_b1_keep",  32'(keep_m), 32'hF);
    chk("t1_b1_last",  32'(last_m), 32'd0);
    chk("t1_b1_ready", 32'(ready_s), 32'b001);
    chk("t1_b1_busy",  32'(busy), 32'd1);
    chk("t1_b1_grant", 32'(grant_idx), 32'd0);
    cyc();
    set_src(0, 1'b1, 32'h22, 4'hF, 1'b0);
    settle();
    chk("t1_b2_data", data_m, 32'h22);
    cyc();
    set_src(0, 1'b1, 32'h33, 4'h3, 1'b1);
    settle();
    chk("t1_b3_data", data_m, 32'h33);
    chk("t1_b3_keep", 32'(keep_m), 32'h3);
    chk("t1_b3_last", 32'(last_m), 32'd1);
    cyc();
    set_src(0, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("t1_end_busy",  32'(busy), 32'd0);
    chk("t1_end_valid", 32'(valid_m), 32'd0);
    chk("t1_end_grant", 32'(grant_idx), 32'd0);

    // ---------------- contention, src0 and src1 continuously valid
    do_reset();
    ready_m = 1'b1;
    set_src(0, 1'b1, 32'hA0, 4'hF, 1'b0);
    set_src(1, 1'b1, 32'hB0, 4'hF, 1'b0);
    settle();
    chk("t2_idle_ready", 32'(ready_s), 32'd0);
    cyc();
    settle();
    chk("t2_p1_grant", 32'(grant_idx), 32'd0);
    chk("t2_p1_data0", data_m, 32'hA0);
    chk("t2_p1_ready", 32'(ready_s), 32'b001);
    cyc();
    set_src(0, 1'b1, 32'hA1, 4'hF, 1'b1);
    settle();
    chk("t2_p1_data1", data_m, 32'hA1);
    chk("t2_p1_last",  32'(last_m), 32'd1);
    chk("t2_p1_ready1", 32'(ready_s), 32'b001);
    cyc();
    set_src(0, 1'b1, 32'hA0, 4'hF, 1'b0);
    settle();
    chk("t2_bub1_valid", 32'(valid_m), 32'd0);
    chk("t2_bub1_busy",  32'(busy), 32'd0);
    cyc();
    settle();
    chk("t2_p2_grant", 32'(grant_idx), 32'd1);
    chk("t2_p2_data0", data_m, 32'hB0);
    chk("t2_p2_ready", 32'(ready_s), 32'b010);
    cyc();
    set_src(1, 1'b1, 32'hB1, 4'hF, 1'b1);
    settle();
    chk("t2_p2_data1", data_m, 32'hB1);
    cyc();
    set_src(1, 1'b1, 32'hB0, 4'hF, 1'b0);
    settle();
    chk("t2_bub2_valid", 32'(valid_m), 32'd0);
    cyc();
    settle();
    chk("t2_p3_grant", 32'(grant_idx), 32'd0);
    chk("t2_p3_data0", data_m, 32'hA0);
    chk("t2_p3_ready", 32'(ready_s), 32'b001);
    cyc();
    set_src(0, 1'b1, 32'hA1, 4'hF, 1'b1);
    settle();
    chk("t2_p3_data1", data_m, 32'hA1);
    cyc();
    set_src(0, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("t2_bub3_valid", 32'(valid_m), 32'd0);
    cyc();
    settle();
    chk("t2_p4_grant", 32'(grant_idx), 32'd1);
    chk("t2_p4_data0", data_m, 32'hB0);
    cyc();
    set_src(1, 1'b1, 32'hB1, 4'hF, 1'b1);
    settle();
    chk("t2_p4_data1", data_m, 32'hB1);
    cyc();
    set_src(1, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("t2_end_busy", 32'(busy), 32'd0);

    // ---------------- backpressure, stall, competing source
    cyc();
    ready_m = 1'b1;
    set_src(0, 1'b1, 32'hC0, 4'hF, 1'b0);
    settle();
    cyc();
    ready_m = 1'b0;
    set_src(1, 1'b1, 32'hD0, 4'hF, 1'b1);
    settle();
    chk("t3_c1_grant", 32'(grant_idx), 32'd0);
    chk("t3_c1_data",  data_m, 32'hC0);
    chk("t3_c1_ready", 32'(ready_s), 32'b000);
    cyc();
    ready_m = 1'b1;
    settle();
    chk("t3_c2_data",  data_m, 32'hC0);
    chk("t3_c2_ready", 32'(ready_s), 32'b001);
    cyc();
    ready_m = 1'b0;
    set_src(0, 1'b0, 32'hC1, 4'hF, 1'b0);
    settle();
    chk("t3_c3_valid", 32'(valid_m), 32'd0);
    chk("t3_c3_busy",  32'(busy), 32'd1);
    chk("t3_c3_grant", 32'(grant_idx), 32'd0);
    cyc();
    ready_m = 1'b1;
    settle();
    chk("t3_c4_valid", 32'(valid_m), 32'd0);
    chk("t3_c4_ready", 32'(ready_s), 32'b001);
    cyc();
    ready_m = 1'b0;
    set_src(0, 1'b1, 32'hC1, 4'hF, 1'b0);
    settle();
    chk("t3_c5_data", data_m, 32'hC1);
    chk("t3_c5_ready", 32'(ready_s), 32'b000);
    cyc();
    ready_m = 1'b1;
    settle();
    chk("t3_c6_data", data_m, 32'hC1);
    cyc();
    set_src(0, 1'b1, 32'hC2, 4'hF, 1'b1);
    settle();
    chk("t3_c7_data",  data_m, 32'hC2);
    chk("t3_c7_grant", 32'(grant_idx), 32'd0);
    chk("t3_c7_last",  32'(last_m), 32'd1);
    cyc();
    set_src(0, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("t3_c8_busy",  32'(busy), 32'd0);
    chk("t3_c8_ready", 32'(ready_s), 32'b000);
    cyc();
    settle();
    chk("t3_d_grant", 32'(grant_idx), 32'd1);
    chk("t3_d_data",  data_m, 32'hD0);
    chk("t3_d_ready", 32'(ready_s), 32'b010);
    cyc();
    set_src(1, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("t3_end_busy", 32'(busy), 32'd0);

    // ---------------- single-beat packet, then reset mid-packet
    cyc();
    set_src(0, 1'b1, 32'h5A, 4'hF, 1'b1);
    settle();
    cyc();
    settle();
    chk("t4_sb_data", data_m, 32'h5A);
    chk("t4_sb_last", 32'(last_m), 32'd1);
    cyc();
    set_src(0, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("t4_sb_busy", 32'(busy), 32'd0);
    cyc();
    set_src(0, 1'b1, 32'hE0, 4'hF, 1'b0);
    settle();
    cyc();
    settle();
    chk("t4_e0_data", data_m, 32'hE0);
    cyc();
    set_src(0, 1'b1, 32'hE1, 4'hF, 1'b0);
    rst = 1'b1;
    settle();
    chk("t4_e1_data", data_m, 32'hE1);
    cyc();
    rst = 1'b0;
    set_src(0, 1'b1, 32'hF0, 4'hF, 1'b1);
    set_src(1, 1'b1, 32'h60, 4'hF, 1'b1);
    settle();
    chk("t4_rst_valid", 32'(valid_m), 32'd0);
    chk("t4_rst_ready", 32'(ready_s), 32'd0);
    chk("t4_rst_busy",  32'(busy), 32'd0);
    chk("t4_rst_last",  32'(last_m), 32'd0);
    cyc();
    settle();
    chk("t4_after_grant", 32'(grant_idx), 32'd0);
    chk("t4_after_data",  data_m, 32'hF0);
    cyc();
    set_src(0, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    cyc();
    settle();
    chk("t4_next_grant", 32'(grant_idx), 32'd1);
    chk("t4_next_data",  data_m, 32'h60);
    cyc();
    set_src(1, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();

    // ---------------- oversize: 6 beats with MAX_BEATS=4
    cyc();
    set_src(0, 1'b1, 32'h50, 4'hF, 1'b0);
    settle();
    cyc();
    for (int b = 0; b < 6; b++) begin
      settle();
      chk("t5_data",  data_m, 32'h50 + 32'(b));
      chk("t5_valid", 32'(valid_m), 32'd1);
      chk("t5_err",   32'(err_oversize), 32'(b >= 5));
      cyc();
      if (b < 5) set_src(0, 1'b1, 32'h50 + 32'(b + 1), 4'hF, ((b + 1) == 5));
      else       set_src(0, 1'b0, 32'h0, 4'h0, 1'b0);
    end
    settle();
    chk("t5_end_busy", 32'(busy), 32'd0);
    chk("t5_end_err",  32'(err_oversize), 32'd1);

    // ---------------- wrap: make last_grant=2, then src0 and src2 request
    cyc();
    set_src(2, 1'b1, 32'h70, 4'hF, 1'b1);
    settle();
    cyc();
    settle();
    chk("t6_k0_grant", 32'(grant_idx), 32'd2);
    chk("t6_k0_data",  data_m, 32'h70);
    chk("t6_k0_ready", 32'(ready_s), 32'b100);
    cyc();
    set_src(2, 1'b1, 32'h71, 4'hF, 1'b1);
    set_src(0, 1'b1, 32'h80, 4'hF, 1'b1);
    settle();
    chk("t6_idle_valid", 32'(valid_m), 32'd0);
    cyc();
    settle();
    chk("t6_w1_grant", 32'(grant_idx), 32'd0);
    chk("t6_w1_data",  data_m, 32'h80);
    cyc();
    set_src(0, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    cyc();
    settle();
    chk("t6_w2_grant", 32'(grant_idx), 32'd2);
    chk("t6_w2_data",  data_m, 32'h71);
    cyc();
    set_src(2, 1'b0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("t6_end_busy", 32'(busy), 32'd0);
    chk("t6_end_err",  32'(err_oversize), 32'd1);

    // ---------------- final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
